sprite_cmd_encoder: RTL and testbench
=====================================

Name: sprite_cmd_encoder

Overview:
Host-side command encoder that builds the 32-bit sprite command words consumed by the display components (Tube_display and siblings) on their shared `writedata` bus. It accepts whole-sprite update requests through a valid/ready interface and buffers them in a small FIFO. Each request is serialised into per-field write words aimed at the current back buffer. On a frame-boundary request it emits the buffer-swap word, so sprite updates are applied atomically per frame.

Parameters:
- DEPTH, 4: request FIFO depth (power of 2, ≥2).
- CHILD_LIMIT, 2: number of valid child indices; requests with `req_child` ≥ CHILD_LIMIT are rejected.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_comp  in  6  target component ID (`sub_comp`)
- req_child  in  5  child index
- req_mask  in  4  words to send: [0] attr, [1] x, [2] y, [3] shift
- req_visible  in  1  visible bit
- req_flip  in  1  flip bit
- req_pattern  in  5  pattern code
- req_x  in  10  x coordinate
- req_y  in  10  y coordinate
- req_shift  in  10  shift amount
- swap_req  in  1  frame-boundary pulse (vblank)
- writedata  out  32  command word to the display components
- back_buf  out  1  buffer currently being written
- swap_done  out  1  one-cycle pulse, asserted in the cycle the swap word is driven
- req_err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Word format:
  - [31:26] `sub_comp`, [25:21] child, [20:17] info, [16:14] type, [13] `buffer_select`, [12:0] msg.
  - Write words use info = 4'b0001 and `buffer_select` = `back_buf`.
  - Type 001 (attr): msg[12] = visible, msg[11] = flip, msg[4:0] = pattern, other msg bits 0.
  - Type 010 (x), 011 (y), 100 (shift): msg[9:0] = value, msg[12:10] = 0.
  - Swap word: info = 4'b1111, [13] = `back_buf`, all other bits 0.
  - Idle word: 32'h0. Info = 0 is a no-op at the receivers.
- Reset values: `writedata` = 0, `back_buf` = 1, `swap_done` = 0, `req_err` = 0, FIFO empty, swap-pending = 0, FSM in IDLE.
- FIFO:
  - A push happens when `req_valid` && `req_ready`.
  - `req_ready` = !full, combinationally. A push and a pop in the same cycle while full are not allowed; `req_ready` is based on full only.
  - A request with `req_child` ≥ CHILD_LIMIT is accepted but discarded: pulse `req_err` in the next cycle and do not push.
  - A request with `req_mask` = 0 is pushed and produces no words.
- FSM states: IDLE, ATTR, XW, YW, SHW, SWAP.
  - Each non-IDLE state drives exactly one word for one cycle. Between requests, `writedata` returns to 0 for at least one cycle (the IDLE cycle).
  - IDLE: if swap-pending, go to SWAP. Otherwise, if the FIFO is non-empty, pop the head into a working register and go to the first state whose mask bit is set (order: ATTR → XW → YW → SHW). If the mask is 0, stay in IDLE.
  - From each word state, go to the next set mask bit; if none remain, go to IDLE.
  - SWAP: drive the swap word and pulse `swap_done`. `back_buf` toggles at the end of the cycle. Clear swap-pending and go to IDLE.
- Latency: a request pushed at cycle N into an empty FIFO in IDLE produces its first word at cycle N+2 (pop at N+1, word driven at N+2).
- Swap semantics:
  - `swap_req` sets swap-pending. A second `swap_req` while pending is merged (not queued).
  - A request already being serialised always completes before SWAP; swaps never split a request.
  - A swap has priority over the FIFO in IDLE.
- Receiver contract: a swap makes the receivers clear `visible` on all children of the new back buffer. Software must re-send attr words every frame.
- `swap_req` arriving in the same cycle as the SWAP state is counted as a new pending swap.
- Reset mid-operation: everything returns to reset values immediately. A partially sent request is lost and `writedata` drops to 0 asynchronously.

Optional Feature:
- Macro: SPRITE_CMD_STATS_EN.
- When defined:
  - Adds outputs `words_sent` [15:0] (count of non-idle words, wraps at 0xFFFF→0) and `swaps_merged` [7:0] (count of `swap_req` pulses seen while pending, saturating at 0xFF).
  - Both reset to 0.
- When undefined: neither port nor counter exists, and all other behaviour is identical.

Test Plan:
- Reset, then request comp = 15, child = 1, mask = 4'b0011, visible = 1, pattern = 1, x = 100 → `writedata` = 32'h3C227001, then 32'h3C22A064, then 32'h0; `back_buf` = 1.
- `swap_req` pulse while idle → one cycle of `writedata` = 32'h001E2000 with `swap_done` = 1; next cycle `back_buf` = 0 and `writedata` = 0.
- `swap_req` during the x word of a mask = 4'b1111 request → y and shift words are sent first, then the swap word; two `swap_req` pulses yield one swap.
- Push 5 requests back-to-back with DEPTH = 4 and the FSM stalled behind a swap → `req_ready` = 0 after the 4th push; all 4 are emitted in order.
- Request with child = 2 (CHILD_LIMIT = 2) → `req_err` pulse; no words are emitted.
- Assert `reset` mid-request → `writedata` = 0 immediately, FIFO empty, `back_buf` = 1; the next request is encoded with `buffer_select` = 1.

Source files
------------

// File: rtl/sprite_cmd_encoder.sv
// sprite_cmd_encoder: buffers whole-sprite update requests and serialises them
// into 32-bit per-field write words on writedata, aimed at the back buffer.
// A frame-boundary swap_req emits the buffer-swap word between requests.
//
// Optional build macro SPRITE_CMD_STATS_EN adds the words_sent and
// swaps_merged statistics outputs.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | writedata = 0; start a pending swap or pop the next request
// ATTR  | drive attr word (visible, flip, pattern)
// XW    | drive x coordinate word
// YW    | drive y coordinate word
// SHW   | drive shift word
// SWAP  | drive swap word, pulse swap_done, toggle back_buf at cycle end
module sprite_cmd_encoder #(
  parameter int DEPTH       = 4,
  parameter int CHILD_LIMIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_comp,
  input  logic [4:0]  req_child,
  input  logic [3:0]  req_mask,
  input  logic        req_visible,
  input  logic        req_flip,
  input  logic [4:0]  req_pattern,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  input  logic [9:0]  req_shift,
  input  logic        swap_req,
  output logic [31:0] writedata,
  output logic        back_buf,
  output logic        swap_done,
  output logic        req_err
`ifdef SPRITE_CMD_STATS_EN
  ,
  output logic [15:0] words_sent,
  output logic [7:0]  swaps_merged
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [5:0] comp;
    logic [4:0] child;
    logic [3:0] mask;
    logic       visible;
    logic       flip;
    logic [4:0] pattern;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] shift;
  } req_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ATTR = 3'd1,
    XW   = 3'd2,
    YW   = 3'd3,
    SHW  = 3'd4,
    SWAP = 3'd5
  } state_t;

  state_t        state, state_nxt;
  req_t          mem [DEPTH];
  req_t          in_req, head, work;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop, child_bad;
  logic          swap_pend;

  // First word state whose mask bit is set, in ATTR -> XW -> YW -> SHW order.
  function automatic state_t first_set(input logic [3:0] m);
    if (m[0])      return ATTR;
    else if (m[1]) return XW;
    else if (m[2]) return YW;
    else if (m[3]) return SHW;
    else           return IDLE;
  endfunction

  assign in_req = '{comp: req_comp, child: req_child, mask: req_mask,
                    visible: req_visible, flip: req_flip, pattern: req_pattern,
                    x: req_x, y: req_y, shift: req_shift};

  assign child_bad = (32'(req_child) >= 32'(CHILD_LIMIT));
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign req_ready = !full;
  // Out-of-range children are accepted (handshake completes) but dropped.
  assign push      = req_valid && req_ready && !child_bad;
  assign head      = mem[rd_ptr[AW-1:0]];
  assign swap_done = (state == SWAP);

  // FIFO storage; no reset needed since the pointers qualify the contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_req;
  end

  // FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // State register, working request, buffer select, swap-pending flag, error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      work      <= '0;
      back_buf  <= 1'b1;
      swap_pend <= 1'b0;
      req_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (pop) work <= head;
      if (state == SWAP) back_buf <= !back_buf;
      // A swap_req coinciding with SWAP re-arms the flag for the next frame.
      swap_pend <= swap_req || (swap_pend && (state != SWAP));
      req_err   <= req_valid && req_ready && child_bad;
    end
  end

  // Next-state and pop decision; swaps win in IDLE but never split a request.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (swap_pend) begin
          state_nxt = SWAP;
        end else if (!empty) begin
          pop       = 1'b1;
          state_nxt = first_set(head.mask);
        end
      end
      ATTR:    state_nxt = first_set({work.mask[3:1], 1'b0});
      XW:      state_nxt = first_set({work.mask[3:2], 2'b00});
      YW:      state_nxt = first_set({work.mask[3], 3'b000});
      SHW:     state_nxt = IDLE;
      SWAP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Word formatting; decoded from state so reset clears writedata at once.
  always_comb begin
    writedata = 32'h0;
    case (state)
      ATTR: writedata = {work.comp, work.child, 4'b0001, 3'b001, back_buf,
                         work.visible, work.flip, 6'b0, work.pattern};
      XW:   writedata = {work.comp, work.child, 4'b0001, 3'b010, back_buf,
                         3'b0, work.x};
      YW:   writedata = {work.comp, work.child, 4'b0001, 3'b011, back_buf,
                         3'b0, work.y};
      SHW:  writedata = {work.comp, work.child, 4'b0001, 3'b100, back_buf,
                         3'b0, work.shift};
      SWAP: writedata = {6'b0, 5'b0, 4'b1111, 3'b000, back_buf, 13'b0};
      default: writedata = 32'h0;
    endcase
  end

`ifdef SPRITE_CMD_STATS_EN
  // Statistics: wrapping word counter and saturating merged-swap counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_sent   <= '0;
      swaps_merged <= '0;
    end else begin
      if (state != IDLE) words_sent <= words_sent + 16'd1;
      if (swap_req && swap_pend && (state != SWAP) && (swaps_merged != 8'hFF))
        swaps_merged <= swaps_merged + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Directed bench for sprite_cmd_encoder: table of single-request vectors plus
// hand-written sequences for latency, swap merging, FIFO full and reset.
module tb_sprite_cmd_encoder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_comp;
  logic [4:0]  req_child;
  logic [3:0]  req_mask;
  logic        req_visible;
  logic        req_flip;
  logic [4:0]  req_pattern;
  logic [9:0]  req_x;
  logic [9:0]  req_y;
  logic [9:0]  req_shift;
  logic        swap_req;
  logic [31:0] writedata;
  logic        back_buf;
  logic        swap_done;
  logic        req_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] seen  [$];
  logic [31:0] exp_q [$];

  typedef struct packed {
    logic [5:0]       comp;
    logic [4:0]       child;
    logic [3:0]       mask;
    logic             vis;
    logic             flip;
    logic [4:0]       pat;
    logic [9:0]       x;
    logic [9:0]       y;
    logic [9:0]       sh;
    logic             err;
    logic [2:0]       n;
    logic [3:0][31:0] w;
  } vec_t;

  vec_t tbl [8];

  sprite_cmd_encoder #(.DEPTH(4), .CHILD_LIMIT(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_comp(req_comp), .req_child(req_child), .req_mask(req_mask),
    .req_visible(req_visible), .req_flip(req_flip), .req_pattern(req_pattern),
    .req_x(req_x), .req_y(req_y), .req_shift(req_shift),
    .swap_req(swap_req), .writedata(writedata), .back_buf(back_buf),
    .swap_done(swap_done), .req_err(req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every non-idle word in order.
  always @(negedge clk) begin
    if (!reset && writedata != 32'h0) seen.push_back(writedata);
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [5:0] comp, input logic [4:0] child,
                              input logic [3:0] mask, input logic vis, input logic flip,
                              input logic [4:0] pat, input logic [9:0] x, input logic [9:0] y,
                              input logic [9:0] sh, input logic err, input logic [2:0] n,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
    vec_t v;
    v.comp = comp; v.child = child; v.mask = mask; v.vis = vis; v.flip = flip;
    v.pat = pat; v.x = x; v.y = y; v.sh = sh; v.err = err; v.n = n;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; drives one request for one cycle, returns at posedge+1.
  task automatic push_req(input logic [5:0] comp, input logic [4:0] child,
                          input logic [3:0] mask, input logic vis, input logic flip,
                          input logic [4:0] pat, input logic [9:0] x,
                          input logic [9:0] y, input logic [9:0] sh);
    req_valid = 1'b1; req_comp = comp; req_child = child; req_mask = mask;
    req_visible = vis; req_flip = flip; req_pattern = pat;
    req_x = x; req_y = y; req_shift = sh;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic check_seen(input string name);
    chk($sformatf("%s_count", name), 32'(seen.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < seen.size()) chk($sformatf("%s_w%0d", name, i), seen[i], exp_q[i]);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_comp = '0; req_child = '0; req_mask = '0;
    req_visible = 1'b0; req_flip = 1'b0; req_pattern = '0; req_x = '0; req_y = '0;
    req_shift = '0; swap_req = 1'b0;

    // Vectors computed with buffer_select = 1.
    tbl[0] = mk(6'd15, 5'd1, 4'b0011, 1, 0, 5'd1, 10'd100, 10'd0, 10'd0, 0, 3'd2,
                32'h3C227001, 32'h3C22A064, 32'h0, 32'h0);
    tbl[1] = mk(6'd63, 5'd0, 4'b1111, 0, 1, 5'd31, 10'd1023, 10'd0, 10'd512, 0, 3'd4,
                32'hFC02681F, 32'hFC02A3FF, 32'hFC02E000, 32'hFC032200);
    tbl[2] = mk(6'd0, 5'd1, 4'b0100, 1, 1, 5'd7, 10'd9, 10'd5, 10'd9, 0, 3'd1,
                32'h0022E005, 32'h0, 32'h0, 32'h0);
    tbl[3] = mk(6'd1, 5'd0, 4'b1000, 1, 0, 5'd0, 10'd1, 10'd2, 10'h3FF, 0, 3'd1,
                32'h040323FF, 32'h0, 32'h0, 32'h0);
    tbl[4] = mk(6'd2, 5'd1, 4'b0000, 1, 1, 5'd3, 10'd1, 10'd2, 10'd3, 0, 3'd0,
                32'h0, 32'h0, 32'h0, 32'h0);
    tbl[5] = mk(6'd9, 5'd2, 4'b1111, 1, 1, 5'd3, 10'd1, 10'd2, 10'd3, 1, 3'd0,
                32'h0, 32'h0, 32'h0, 32'h0);
    tbl[6] = mk(6'd9, 5'd31, 4'b0001, 1, 0, 5'd3, 10'd1, 10'd2, 10'd3, 1, 3'd0,
                32'h0, 32'h0, 32'h0, 32'h0);
    tbl[7] = mk(6'd5, 5'd0, 4'b0101, 1, 1, 5'd10, 10'd0, 10'h2AA, 10'd0, 0, 3'd2,
                32'h14027800 | 32'h0A, 32'h1402E2AA, 32'h0, 32'h0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_back_buf", 32'(back_buf), 32'd1);
    chk("rst_swap_done", 32'(swap_done), 32'd0);
    chk("rst_req_err", 32'(req_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    wait_cycles(2);

    // First-word latency and word sequence.
    push_req(6'd15, 5'd1, 4'b0011, 1, 0, 5'd1, 10'd100, 10'd0, 10'd0);
    chk("lat_idle", writedata, 32'h0);
    wait_cycles(1);
    chk("lat_attr", writedata, 32'h3C227001);
    wait_cycles(1);
    chk("lat_x", writedata, 32'h3C22A064);
    wait_cycles(1);
    chk("lat_end", writedata, 32'h0);
    chk("lat_back_buf", 32'(back_buf), 32'd1);
    wait_cycles(2);

    // Swap while idle.
    swap_req = 1'b1;
    wait_cycles(1);
    swap_req = 1'b0;
    chk("swap_pre", writedata, 32'h0);
    wait_cycles(1);
    chk("swap_word", writedata, 32'h001E2000);
    chk("swap_done_hi", 32'(swap_done), 32'd1);
    wait_cycles(1);
    chk("swap_back_buf", 32'(back_buf), 32'd0);
    chk("swap_after", writedata, 32'h0);
    chk("swap_done_lo", 32'(swap_done), 32'd0);
    wait_cycles(2);

    // Swap requests during a 4-word request: merged, deferred until it completes.
    seen.delete();
    push_req(6'd3, 5'd1, 4'b1111, 1, 0, 5'd2, 10'd10, 10'd20, 10'd30);
    wait_cycles(2);
    chk("merge_xw", writedata, 32'h0C22800A);
    swap_req = 1'b1;
    wait_cycles(1);
    swap_req = 1'b0;
    wait_cycles(1);
    swap_req = 1'b1;
    wait_cycles(1);
    swap_req = 1'b0;
    wait_cycles(10);
    exp_q = '{32'h0C225002, 32'h0C22800A, 32'h0C22C014, 32'h0C23001E, 32'h001E0000};
    check_seen("merge");
    chk("merge_back_buf", 32'(back_buf), 32'd1);

    // Table vectors, buffer_select = 1.
    for (int t = 0; t < 8; t++) begin
      seen.delete();
      push_req(tbl[t].comp, tbl[t].child, tbl[t].mask, tbl[t].vis, tbl[t].flip,
               tbl[t].pat, tbl[t].x, tbl[t].y, tbl[t].sh);
      chk($sformatf("vec%0d_err", t), 32'(req_err), 32'(tbl[t].err));
      wait_cycles(1);
      chk($sformatf("vec%0d_err_clr", t), 32'(req_err), 32'd0);
      wait_cycles(9);
      exp_q.delete();
      for (int k = 0; k < 4; k++) if (k < int'(tbl[t].n)) exp_q.push_back(tbl[t].w[k]);
      check_seen($sformatf("vec%0d", t));
    end

    // FIFO fill while the FSM is held in back-to-back swaps.
    seen.delete();
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_comp = 6'(i + 1); req_child = 5'd0; req_mask = 4'b0001;
      req_visible = 1'b1; req_flip = 1'b0; req_pattern = 5'(i);
      swap_req = (i < 4);
      if (i == 4) chk("full_ready", 32'(req_ready), 32'd0);
      else        chk($sformatf("fill_ready%0d", i), 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    swap_req  = 1'b0;
    wait_cycles(16);
    exp_q = '{32'h001E2000, 32'h001E0000};
    for (int i = 0; i < 4; i++) exp_q.push_back((32'(i + 1) << 26) | 32'h00027000 | 32'(i));
    check_seen("fill");
    chk("fill_back_buf", 32'(back_buf), 32'd1);

    // Reset in the middle of a request.
    swap_req = 1'b1;
    wait_cycles(1);
    swap_req = 1'b0;
    wait_cycles(4);
    chk("pre_rst_back_buf", 32'(back_buf), 32'd0);
    push_req(6'd7, 5'd1, 4'b1111, 1, 0, 5'd3, 10'd1, 10'd2, 10'd3);
    push_req(6'd8, 5'd1, 4'b0001, 1, 0, 5'd3, 10'd1, 10'd2, 10'd3);
    wait_cycles(1);
    chk("mid_xw", writedata, 32'h1C220000 | 32'h00008001);
    reset = 1'b1;
    #2;
    chk("mid_rst_writedata", writedata, 32'h0);
    chk("mid_rst_back_buf", 32'(back_buf), 32'd1);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    #3;
    reset = 1'b0;
    wait_cycles(1);
    seen.delete();
    wait_cycles(10);
    exp_q.delete();
    check_seen("mid_rst_flush");
    push_req(6'd7, 5'd1, 4'b0001, 1, 0, 5'd3, 10'd0, 10'd0, 10'd0);
    wait_cycles(6);
    exp_q = '{32'h1C227003};
    check_seen("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
